mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline; sits directly downstream of the execute stage and consumes its EX/MEM register outputs.
- Issues data-memory reads and writes. For stores, generates the byte mask and lane-aligned write data. For loads, extracts and sign- or zero-extends the loaded value.
- Waits for a ready-handshake memory and stalls the pipeline while it waits.
- Produces the MEM/WB register that feeds write-back.

Parameters:
- TIMEOUT, 16: maximum cycles spent in WAIT before an access is aborted. A value of 0 disables the timeout.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_vld  in  1  EX/MEM entry valid
- i_res  in  32  ALU result (memory address, or write-back value)
- i_rs2_rdata  in  32  store data
- i_opsel  in  3  funct3 (access width and signedness)
- i_mem_read  in  1  load
- i_mem_write  in  1  store
- i_mem_reg  in  1  write-back selects load data
- i_rd_waddr  in  5  destination register
- i_rd_wen  in  1  destination write enable
- i_inst  in  32  instruction (retire trace)
- i_pc  in  32  instruction PC (retire trace)
- i_nxt_pc  in  32  next PC (retire trace)
- o_dmem_addr  out  32  word-aligned address ({i_res[31:2],2'b00})
- o_dmem_ren  out  1  read request
- o_dmem_wen  out  1  write request
- o_dmem_mask  out  4  byte enables
- o_dmem_wdata  out  32  lane-replicated store data
- i_dmem_ready  in  1  memory completes the current request this cycle
- i_dmem_rdata  in  32  read data, valid when i_dmem_ready=1
- o_stall  out  1  hold all upstream stages
- o_err  out  1  one-cycle pulse when an access times out
- o_wb_data  out  32  registered write-back value
- o_rd_waddr  out  5  registered destination register
- o_rd_wen  out  1  registered destination write enable
- o_vld  out  1  registered valid
- o_inst  out  32  registered instruction
- o_pc  out  32  registered PC
- o_nxt_pc  out  32  registered next PC
- o_trap  out  1  registered misalignment trap (MISALIGN_TRAP_EN only; tied to 0 otherwise)

Behaviour:
- Clock and reset: clock i_clk; reset i_rst, synchronous, active-high.
- Reset values:
  - FSM=IDLE, timeout counter=0.
  - o_vld=0, o_rd_waddr=0, o_rd_wen=1, o_wb_data=0, o_inst=32'h00000033, o_pc=0, o_nxt_pc=0, o_trap=0, o_err=0.
  - o_stall=0; dmem requests deasserted.
- Access definition: acc = i_vld & (i_mem_read | i_mem_write).
  - The request outputs are combinational: o_dmem_ren = acc & i_mem_read; o_dmem_wen = acc & i_mem_write.
  - Requests stay asserted and stable throughout WAIT; upstream holds its inputs while o_stall=1.
- Store mask (off = i_res[1:0]):
  - SB: 4'b0001<<off.
  - SH: 4'b0011<<{off[1],1'b0}.
  - SW: 4'b1111.
- Store write data:
  - SB: byte replicated to all 4 lanes.
  - SH: halfword replicated to both halves.
  - SW: word as-is.
- Load extraction from i_dmem_rdata by off:
  - LB/LBU (000/100): selected byte, sign- or zero-extended.
  - LH/LHU (001/101): selected halfword, sign- or zero-extended.
  - LW (010): full word.
  - Other funct3 values: full word.
- FSM:
  - IDLE: if acc & i_dmem_ready, complete this cycle. If acc & !i_dmem_ready, go to WAIT, counter=1, o_stall=1. If no access, pass through.
  - WAIT: o_stall=1 and counter increments each cycle. If i_dmem_ready, complete and return to IDLE with o_stall=0 in that cycle. If TIMEOUT!=0 and counter==TIMEOUT, abort: return to IDLE, pulse o_err, and retire with rd_wen=0 and wb_data=0.
- MEM/WB register:
  - On completion or pass-through, captures o_wb_data = i_mem_reg ? load_data : i_res, plus all control and trace fields.
  - On every cycle with o_stall=1, captures a bubble: vld=0, rd_wen=0.
  - Latency: 1 cycle for a ready-same-cycle access; N+1 cycles for N wait cycles.
- Boundary conditions:
  - i_vld=0 with mem flags set: no request is issued; the entry passes through as a bubble.
  - Store complete: no write-back unless i_rd_wen is set. rd=x0 writes are passed through unchanged; the register file ignores them.
  - Reset during WAIT: FSM returns to IDLE, requests drop the same cycle as reset, and the access is discarded.
  - Ready arrives on the same cycle the counter reaches TIMEOUT: ready wins; the access completes and there is no o_err.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - An LH/LHU/SH with off[0]=1, or an LW/SW with off!=0, is treated as misaligned.
  - A misaligned access issues no request and has no stall.
  - It retires next cycle with o_trap=1, o_rd_wen=0, o_vld=1.
- MISALIGN_TRAP_EN undefined:
  - Low offset bits below the access width are ignored: halfword accesses use {off[1],0}; word accesses use off=0.
  - o_trap is tied to 0.

Decomposition:
- Shared package holds:
  - funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW.
  - FSM state encoding (IDLE/WAIT).
  - Reset-NOP constant 32'h00000033.
- Sub-module mem_align: purely combinational.
  - Inputs: funct3, off, rs2 data, rdata.
  - Outputs: mask, wdata, load_data, misaligned flag.

Test Plan:
- SB of rs2=32'h000000AB to res=32'h1003, ready same cycle -> mask=4'b1000, wdata=32'hABABABAB, addr=32'h1000, o_stall=0, o_vld=1 next cycle.
- LB at off=2 with rdata=32'h00800000 -> o_wb_data=32'hFFFFFF80; the same access as LBU -> o_wb_data=32'h00000080.
- LW with ready delayed 3 cycles -> o_stall high for exactly 3 cycles, three bubbles (o_vld=0) retire, then the load retires with o_wb_data=rdata.
- Load with ready never asserted, TIMEOUT=16 -> o_err pulses 16 cycles after issue, the entry retires with rd_wen=0, and the FSM returns to IDLE.
- Reset asserted in WAIT cycle 2 -> next cycle o_stall=0, ren=0, o_vld=0, o_inst=32'h00000033.
- LW to res=32'h1002 -> with MISALIGN_TRAP_EN: ren=0 and o_trap=1 next cycle. Without it: addr=32'h1000, a normal word load.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared definitions for the RV32I memory-access stage:
//   - funct3 encodings for loads and stores
//   - FSM state encoding for the memory handshake (IDLE/WAIT)
//   - NOP instruction presented on the retire trace after reset
package mem_stage_pkg;

  // Load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Handshake FSM states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // add x0,x0,x0
  localparam logic [31:0] NOP_INST = 32'h00000033;

endpackage

// File: rtl/mem_align.sv
// mem_align
// Purely combinational lane alignment for data-memory accesses.
// Ports:
//   funct3     in   access width / signedness
//   off        in   byte offset within the word (address bits [1:0])
//   rs2_data   in   store data from the register file
//   rdata      in   word returned by data memory
//   mask       out  byte enables for stores
//   wdata      out  store data replicated across lanes
//   load_data  out  extracted and extended load value
//   misaligned out  offset is not a multiple of the access size
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rs2_data,
  input  logic [31:0] rdata,
  output logic [3:0]  mask,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  // Halfword accesses ignore off[0]; word accesses ignore the offset
  // entirely. Misaligned accesses are caught separately when trapping.
  logic [1:0]  half_off;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign half_off = {off[1], 1'b0};
  assign sel_half = half_off[1] ? rdata[31:16] : rdata[15:0];

  // Byte lane select for loads
  always_comb begin
    sel_byte = rdata[7:0];
    case (off)
      2'd0: sel_byte = rdata[7:0];
      2'd1: sel_byte = rdata[15:8];
      2'd2: sel_byte = rdata[23:16];
      2'd3: sel_byte = rdata[31:24];
      default: sel_byte = rdata[7:0];
    endcase
  end

  // Store mask and lane replication; memory picks the lanes via the mask
  always_comb begin
    mask  = 4'b1111;
    wdata = rs2_data;
    case (funct3)
      SB: begin
        mask  = 4'b0001 << off;
        wdata = {4{rs2_data[7:0]}};
      end
      SH: begin
        mask  = 4'b0011 << half_off;
        wdata = {2{rs2_data[15:0]}};
      end
      default: begin
        mask  = 4'b1111;
        wdata = rs2_data;
      end
    endcase
  end

  // Load extraction; unknown funct3 values return the full word
  always_comb begin
    load_data = rdata;
    case (funct3)
      LB:      load_data = {{24{sel_byte[7]}}, sel_byte};
      LBU:     load_data = {24'b0, sel_byte};
      LH:      load_data = {{16{sel_half[15]}}, sel_half};
      LHU:     load_data = {16'b0, sel_half};
      default: load_data = rdata;
    endcase
  end

  assign misaligned = (((funct3 == LH) || (funct3 == LHU)) && off[0]) ||
                      ((funct3 == LW) && (off != 2'b00));

endmodule

// File: rtl/mem_stage.sv
// mem_stage
// Memory-access stage of the 5-stage RV32I pipeline. Issues data-memory
// reads/writes over a ready handshake, stalls upstream while waiting,
// aborts after TIMEOUT wait cycles (0 = never), and registers MEM/WB.
// Optional: define MISALIGN_TRAP_EN to trap misaligned halfword/word
// accesses instead of silently aligning them.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_vld .. i_nxt_pc            EX/MEM register inputs
//   o_dmem_*, i_dmem_*           data-memory request / response
//   o_stall                      hold all upstream stages
//   o_err                        one-cycle pulse on access timeout
//   o_wb_data .. o_trap          MEM/WB register outputs
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_vld,
  input  logic [31:0] i_res,
  input  logic [31:0] i_rs2_rdata,
  input  logic [2:0]  i_opsel,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_mem_reg,
  input  logic [4:0]  i_rd_waddr,
  input  logic        i_rd_wen,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_nxt_pc,
  output logic [31:0] o_dmem_addr,
  output logic        o_dmem_ren,
  output logic        o_dmem_wen,
  output logic [3:0]  o_dmem_mask,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ready,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_stall,
  output logic        o_err,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_rd_waddr,
  output logic        o_rd_wen,
  output logic        o_vld,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_nxt_pc,
  output logic        o_trap
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   load_data;
  logic          misaligned;
  logic          acc_raw;
  logic          acc;
  logic          mis_acc;
  logic          in_wait;
  logic          tmo_hit;
  logic          abort;

  mem_align u_align (
    .funct3    (i_opsel),
    .off       (i_res[1:0]),
    .rs2_data  (i_rs2_rdata),
    .rdata     (i_dmem_rdata),
    .mask      (o_dmem_mask),
    .wdata     (o_dmem_wdata),
    .load_data (load_data),
    .misaligned(misaligned)
  );

  assign acc_raw = i_vld & (i_mem_read | i_mem_write);

`ifdef MISALIGN_TRAP_EN
  assign mis_acc = acc_raw & misaligned;
`else
  logic unused_misaligned;
  assign mis_acc = 1'b0;
  assign unused_misaligned = misaligned;
`endif

  // A trapping access never reaches memory
  assign acc     = acc_raw & ~mis_acc;
  assign in_wait = (state == ST_WAIT);
  assign tmo_hit = (TIMEOUT != 0) && (cnt == TMO);

  // Ready on the timeout cycle wins over the abort
  assign abort   = ~i_rst & in_wait & ~i_dmem_ready & tmo_hit;

  // Requests are gated by reset so a WAIT in flight drops immediately
  assign o_dmem_addr = {i_res[31:2], 2'b00};
  assign o_dmem_ren  = ~i_rst & acc & i_mem_read;
  assign o_dmem_wen  = ~i_rst & acc & i_mem_write;

  // Stall releases in the cycle the access completes or aborts so the
  // upstream entry advances exactly once
  assign o_stall = ~i_rst & ~i_dmem_ready & (in_wait ? ~tmo_hit : acc);
  assign o_err   = abort;

  // Handshake FSM and wait-cycle counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (acc && !i_dmem_ready) begin
            state <= ST_WAIT;
            cnt   <= CW'(1);
          end
        end
        ST_WAIT: begin
          if (i_dmem_ready || tmo_hit) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // MEM/WB register: bubbles while stalled, otherwise capture the entry
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_vld      <= 1'b0;
      o_rd_waddr <= '0;
      o_rd_wen   <= 1'b1;
      o_wb_data  <= '0;
      o_inst     <= NOP_INST;
      o_pc       <= '0;
      o_nxt_pc   <= '0;
    end else if (o_stall) begin
      o_vld    <= 1'b0;
      o_rd_wen <= 1'b0;
    end else begin
      o_vld      <= i_vld;
      o_rd_waddr <= i_rd_waddr;
      o_inst     <= i_inst;
      o_pc       <= i_pc;
      o_nxt_pc   <= i_nxt_pc;
      if (abort || mis_acc) begin
        o_rd_wen  <= 1'b0;
        o_wb_data <= '0;
      end else begin
        o_rd_wen  <= i_rd_wen;
        o_wb_data <= i_mem_reg ? load_data : i_res;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Trap flag travels with the retiring entry
  always_ff @(posedge i_clk) begin
    if (i_rst || o_stall) begin
      o_trap <= 1'b0;
    end else begin
      o_trap <= mis_acc;
    end
  end
`else
  assign o_trap = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
// Directed bench for mem_stage. Stimulus pushes expected retirements into
// a scoreboard queue; a monitor pops and compares on every valid retire.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_vld;
  logic [31:0] i_res;
  logic [31:0] i_rs2_rdata;
  logic [2:0]  i_opsel;
  logic        i_mem_read;
  logic        i_mem_write;
  logic        i_mem_reg;
  logic [4:0]  i_rd_waddr;
  logic        i_rd_wen;
  logic [31:0] i_inst;
  logic [31:0] i_pc;
  logic [31:0] i_nxt_pc;
  logic [31:0] o_dmem_addr;
  logic        o_dmem_ren;
  logic        o_dmem_wen;
  logic [3:0]  o_dmem_mask;
  logic [31:0] o_dmem_wdata;
  logic        i_dmem_ready;
  logic [31:0] i_dmem_rdata;
  logic        o_stall;
  logic        o_err;
  logic [31:0] o_wb_data;
  logic [4:0]  o_rd_waddr;
  logic        o_rd_wen;
  logic        o_vld;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic [31:0] o_nxt_pc;
  logic        o_trap;

  typedef struct {
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] pc;
    logic        trap;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   stall_cnt;

  always #5 i_clk = ~i_clk;

  mem_stage #(.TIMEOUT(16)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_vld       (i_vld),
    .i_res       (i_res),
    .i_rs2_rdata (i_rs2_rdata),
    .i_opsel     (i_opsel),
    .i_mem_read  (i_mem_read),
    .i_mem_write (i_mem_write),
    .i_mem_reg   (i_mem_reg),
    .i_rd_waddr  (i_rd_waddr),
    .i_rd_wen    (i_rd_wen),
    .i_inst      (i_inst),
    .i_pc        (i_pc),
    .i_nxt_pc    (i_nxt_pc),
    .o_dmem_addr (o_dmem_addr),
    .o_dmem_ren  (o_dmem_ren),
    .o_dmem_wen  (o_dmem_wen),
    .o_dmem_mask (o_dmem_mask),
    .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_ready(i_dmem_ready),
    .i_dmem_rdata(i_dmem_rdata),
    .o_stall     (o_stall),
    .o_err       (o_err),
    .o_wb_data   (o_wb_data),
    .o_rd_waddr  (o_rd_waddr),
    .o_rd_wen    (o_rd_wen),
    .o_vld       (o_vld),
    .o_inst      (o_inst),
    .o_pc        (o_pc),
    .o_nxt_pc    (o_nxt_pc),
    .o_trap      (o_trap)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic [31:0] res, input logic [31:0] rs2,
                               input logic [2:0] f3, input logic rd_m, input logic wr_m,
                               input logic mreg, input logic [4:0] rd, input logic rdwen,
                               input logic [31:0] pc);
    i_vld       = vld;
    i_res       = res;
    i_rs2_rdata = rs2;
    i_opsel     = f3;
    i_mem_read  = rd_m;
    i_mem_write = wr_m;
    i_mem_reg   = mreg;
    i_rd_waddr  = rd;
    i_rd_wen    = rdwen;
    i_pc        = pc;
    i_inst      = pc ^ 32'h00000013;
    i_nxt_pc    = pc + 32'd4;
  endtask

  task automatic goIdle();
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
  endtask

  task automatic pushExp(input logic [31:0] wb, input logic [4:0] rd, input logic wen,
                         input logic [31:0] pc, input logic trap);
    exp_t e;
    e.wb   = wb;
    e.rd   = rd;
    e.wen  = wen;
    e.pc   = pc;
    e.trap = trap;
    sb_q.push_back(e);
  endtask

  task automatic nextCycle();
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: every valid retirement must match the oldest expectation
  always @(negedge i_clk) begin
    if (!i_rst && o_vld) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_retire: got pc %h, expected no retirement", o_pc);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("wb_data", o_wb_data, mon_e.wb);
        checkOutput("rd_waddr", 32'(o_rd_waddr), 32'(mon_e.rd));
        checkOutput("rd_wen", 32'(o_rd_wen), 32'(mon_e.wen));
        checkOutput("pc", o_pc, mon_e.pc);
        checkOutput("trap", 32'(o_trap), 32'(mon_e.trap));
      end
    end
  end

  // Time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus
  initial begin
    i_rst        = 1'b1;
    i_dmem_ready = 1'b0;
    i_dmem_rdata = 32'h0;
    goIdle();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("rst_vld", 32'(o_vld), 32'd0);
    checkOutput("rst_inst", o_inst, 32'h00000033);
    checkOutput("rst_rd_wen", 32'(o_rd_wen), 32'd1);
    checkOutput("rst_wb_data", o_wb_data, 32'd0);
    checkOutput("rst_stall", 32'(o_stall), 32'd0);
    checkOutput("rst_ren", 32'(o_dmem_ren), 32'd0);
    checkOutput("rst_err", 32'(o_err), 32'd0);
    checkOutput("rst_trap", 32'(o_trap), 32'd0);
    nextCycle();
    i_rst = 1'b0;

    // SB to offset 3, ready same cycle
    i_dmem_ready = 1'b1;
    applyStimulus(1'b1, 32'h1003, 32'h000000AB, SB, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h100);
    pushExp(32'h1003, 5'd0, 1'b0, 32'h100, 1'b0);
    @(negedge i_clk);
    checkOutput("sb_mask", 32'(o_dmem_mask), 32'h8);
    checkOutput("sb_wdata", o_dmem_wdata, 32'hABABABAB);
    checkOutput("sb_addr", o_dmem_addr, 32'h1000);
    checkOutput("sb_wen", 32'(o_dmem_wen), 32'd1);
    checkOutput("sb_ren", 32'(o_dmem_ren), 32'd0);
    checkOutput("sb_stall", 32'(o_stall), 32'd0);
    nextCycle();

    // LB / LBU at offset 2
    i_dmem_rdata = 32'h00800000;
    applyStimulus(1'b1, 32'h2002, 32'h0, LB, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 32'h104);
    pushExp(32'hFFFFFF80, 5'd5, 1'b1, 32'h104, 1'b0);
    @(negedge i_clk);
    checkOutput("lb_ren", 32'(o_dmem_ren), 32'd1);
    checkOutput("lb_addr", o_dmem_addr, 32'h2000);
    nextCycle();
    applyStimulus(1'b1, 32'h2002, 32'h0, LBU, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 32'h108);
    pushExp(32'h00000080, 5'd5, 1'b1, 32'h108, 1'b0);
    nextCycle();

    // LH at offset 2, LHU at offset 3
    i_dmem_rdata = 32'hBEEF1234;
    applyStimulus(1'b1, 32'h2006, 32'h0, LH, 1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 32'h10C);
    pushExp(32'hFFFFBEEF, 5'd6, 1'b1, 32'h10C, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 32'h2007, 32'h0, LHU, 1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 32'h110);
`ifdef MISALIGN_TRAP_EN
    pushExp(32'h0, 5'd6, 1'b0, 32'h110, 1'b1);
`else
    pushExp(32'h0000BEEF, 5'd6, 1'b1, 32'h110, 1'b0);
`endif
    nextCycle();

    // SH and SW; SW writes back to x0 unchanged
    applyStimulus(1'b1, 32'h3002, 32'h1234CAFE, SH, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h114);
    pushExp(32'h3002, 5'd0, 1'b0, 32'h114, 1'b0);
    @(negedge i_clk);
    checkOutput("sh_mask", 32'(o_dmem_mask), 32'hC);
    checkOutput("sh_wdata", o_dmem_wdata, 32'hCAFECAFE);
    nextCycle();
    applyStimulus(1'b1, 32'h3004, 32'hDEADBEEF, SW, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 32'h118);
    pushExp(32'h3004, 5'd0, 1'b1, 32'h118, 1'b0);
    @(negedge i_clk);
    checkOutput("sw_mask", 32'(o_dmem_mask), 32'hF);
    checkOutput("sw_wdata", o_dmem_wdata, 32'hDEADBEEF);
    nextCycle();

    // ALU pass-through: no request, no stall even with memory not ready
    i_dmem_ready = 1'b0;
    applyStimulus(1'b1, 32'h55, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 32'h11C);
    pushExp(32'h55, 5'd7, 1'b1, 32'h11C, 1'b0);
    @(negedge i_clk);
    checkOutput("alu_ren", 32'(o_dmem_ren), 32'd0);
    checkOutput("alu_wen", 32'(o_dmem_wen), 32'd0);
    checkOutput("alu_stall", 32'(o_stall), 32'd0);
    nextCycle();

    // Invalid entry with load flag: no request, retires as bubble
    applyStimulus(1'b0, 32'h6000, 32'h0, LW, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 32'h120);
    @(negedge i_clk);
    checkOutput("inv_ren", 32'(o_dmem_ren), 32'd0);
    checkOutput("inv_stall", 32'(o_stall), 32'd0);
    nextCycle();
    goIdle();
    @(negedge i_clk);
    checkOutput("inv_vld", 32'(o_vld), 32'd0);
    nextCycle();

    // LW with ready delayed 3 cycles
    applyStimulus(1'b1, 32'h4000, 32'h0, LW, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 32'h124);
    stall_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        i_dmem_ready = 1'b1;
        i_dmem_rdata = 32'h11223344;
        pushExp(32'h11223344, 5'd9, 1'b1, 32'h124, 1'b0);
      end
      @(negedge i_clk);
      if (o_stall) stall_cnt++;
      if (k > 0) checkOutput("wait_bubble", 32'(o_vld), 32'd0);
      nextCycle();
    end
    checkOutput("wait_stall_cycles", 32'(stall_cnt), 32'd3);

    // Ready never arrives: abort on the 16th wait cycle
    i_dmem_ready = 1'b0;
    applyStimulus(1'b1, 32'h5000, 32'h0, LW, 1'b1, 1'b0, 1'b1, 5'd10, 1'b1, 32'h128);
    for (int k = 0; k <= 16; k++) begin
      @(negedge i_clk);
      checkOutput("tmo_err", 32'(o_err), (k == 16) ? 32'd1 : 32'd0);
      checkOutput("tmo_stall", 32'(o_stall), (k < 16) ? 32'd1 : 32'd0);
      if (k == 16) pushExp(32'h0, 5'd10, 1'b0, 32'h128, 1'b0);
      nextCycle();
    end
    goIdle();
    @(negedge i_clk);
    checkOutput("tmo_err_after", 32'(o_err), 32'd0);
    checkOutput("tmo_stall_after", 32'(o_stall), 32'd0);
    nextCycle();

    // Ready on the timeout cycle wins
    applyStimulus(1'b1, 32'h5004, 32'h0, LW, 1'b1, 1'b0, 1'b1, 5'd11, 1'b1, 32'h12C);
    for (int k = 0; k <= 16; k++) begin
      if (k == 16) begin
        i_dmem_ready = 1'b1;
        i_dmem_rdata = 32'hA5A5A5A5;
        pushExp(32'hA5A5A5A5, 5'd11, 1'b1, 32'h12C, 1'b0);
      end
      @(negedge i_clk);
      checkOutput("race_err", 32'(o_err), 32'd0);
      if (k == 16) checkOutput("race_stall", 32'(o_stall), 32'd0);
      nextCycle();
    end
    i_dmem_ready = 1'b0;

    // Reset in WAIT cycle 2
    applyStimulus(1'b1, 32'h6000, 32'h0, LW, 1'b1, 1'b0, 1'b1, 5'd12, 1'b1, 32'h130);
    nextCycle();
    nextCycle();
    i_rst = 1'b1;
    @(negedge i_clk);
    checkOutput("rstw_ren_now", 32'(o_dmem_ren), 32'd0);
    checkOutput("rstw_stall_now", 32'(o_stall), 32'd0);
    nextCycle();
    i_rst = 1'b0;
    goIdle();
    @(negedge i_clk);
    checkOutput("rstw_stall", 32'(o_stall), 32'd0);
    checkOutput("rstw_ren", 32'(o_dmem_ren), 32'd0);
    checkOutput("rstw_vld", 32'(o_vld), 32'd0);
    checkOutput("rstw_inst", o_inst, 32'h00000033);
    nextCycle();

    // LW to a non-word-aligned address
    i_dmem_ready = 1'b1;
    i_dmem_rdata = 32'hCAFEF00D;
    applyStimulus(1'b1, 32'h1002, 32'h0, LW, 1'b1, 1'b0, 1'b1, 5'd13, 1'b1, 32'h134);
`ifdef MISALIGN_TRAP_EN
    pushExp(32'h0, 5'd13, 1'b0, 32'h134, 1'b1);
    @(negedge i_clk);
    checkOutput("mis_ren", 32'(o_dmem_ren), 32'd0);
    checkOutput("mis_stall", 32'(o_stall), 32'd0);
`else
    pushExp(32'hCAFEF00D, 5'd13, 1'b1, 32'h134, 1'b0);
    @(negedge i_clk);
    checkOutput("mis_addr", o_dmem_addr, 32'h1000);
    checkOutput("mis_ren", 32'(o_dmem_ren), 32'd1);
`endif
    nextCycle();

    goIdle();
    i_dmem_ready = 1'b0;
    repeat (3) nextCycle();
    @(negedge i_clk);
    checkOutput("queue_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
